// File: rtl/apb_master_fifo.sv
// Queued APB4 requester: a command FIFO feeds an APB transfer engine, and each
// command produces one in-order response through a response FIFO.
module apb_master_fifo #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CMD_DEPTH  = 4,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                        pclk_i,
  input  logic                        prstn_i,
  output logic [ADDR_WIDTH-1:0]       paddr_o,
  output logic [2:0]                  pprot_o,
  output logic                        psel_o,
  output logic                        penable_o,
  output logic                        pwrite_o,
  output logic [DATA_WIDTH-1:0]       pwdata_o,
  output logic [DATA_WIDTH/8-1:0]     pstrb_o,
  input  logic                        pready_i,
  input  logic [DATA_WIDTH-1:0]       prdata_i,
  input  logic                        pslverr_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic                        cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]       cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]       cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]     cmd_strb_i,
  input  logic [2:0]                  cmd_prot_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [DATA_WIDTH-1:0]       rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic                        rsp_timeout_o,
  output logic [$clog2(CMD_DEPTH):0]  cmd_level_o,
  output logic                        busy_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned PTR_W  = $clog2(CMD_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(CMD_DEPTH);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     strb;
    logic [2:0]            prot;
  } cmd_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } rsp_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              psel_d, penable_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              launch;
  logic              timeout_hit;
  logic              can_launch;

  // Command FIFO
  cmd_t              cmd_mem [CMD_DEPTH];
  cmd_t              cmd_din, cmd_head;
  logic [PTR_W-1:0]  cmd_wr_ptr, cmd_rd_ptr;
  logic [LVL_W-1:0]  cmd_count, cmd_count_d;
  logic              cmd_push;

  assign cmd_ready_o = (cmd_count != LVL_FULL);
  assign cmd_push    = cmd_valid_i && cmd_ready_o;
  assign cmd_head    = cmd_mem[cmd_rd_ptr];
  assign cmd_count_d = cmd_count + LVL_W'(cmd_push) - LVL_W'(launch);
  assign cmd_level_o = cmd_count;
  assign cmd_din     = '{write: cmd_write_i, addr: cmd_addr_i, wdata: cmd_wdata_i,
                         strb: cmd_strb_i, prot: cmd_prot_i};

  always_ff @(posedge pclk_i) begin
    if (cmd_push) cmd_mem[cmd_wr_ptr] <= cmd_din;
  end

  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_count  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + PTR_W'(1);
      if (launch)   cmd_rd_ptr <= cmd_rd_ptr + PTR_W'(1);
      cmd_count <= cmd_count_d;
    end
  end

  // Response FIFO
  rsp_t              rsp_mem [CMD_DEPTH];
  rsp_t              rsp_din, rsp_head;
  logic [PTR_W-1:0]  rsp_wr_ptr, rsp_rd_ptr;
  logic [LVL_W-1:0]  rsp_count, rsp_count_nx;
  logic              rsp_push, rsp_pop;

  assign timeout_hit  = (TIMEOUT != 0) && (wait_q == WAIT_LAST);
  assign rsp_push     = (state_q == ST_ACCESS) && (pready_i || timeout_hit);
  assign rsp_valid_o  = (rsp_count != '0);
  assign rsp_pop      = rsp_valid_o && rsp_ready_i;
  assign rsp_count_nx = rsp_count + LVL_W'(rsp_push) - LVL_W'(rsp_pop);
  assign rsp_din      = '{rdata:   (pready_i && !pwrite_o) ? prdata_i : '0,
                          err:     pready_i ? pslverr_i : 1'b1,
                          timeout: !pready_i};
  assign rsp_head      = rsp_mem[rsp_rd_ptr];
  assign rsp_rdata_o   = rsp_valid_o ? rsp_head.rdata : '0;
  assign rsp_err_o     = rsp_valid_o && rsp_head.err;
  assign rsp_timeout_o = rsp_valid_o && rsp_head.timeout;

  always_ff @(posedge pclk_i) begin
    if (rsp_push) rsp_mem[rsp_wr_ptr] <= rsp_din;
  end

  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_count  <= '0;
    end else begin
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + PTR_W'(1);
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + PTR_W'(1);
      rsp_count <= rsp_count_nx;
    end
  end

  // A launch reserves a response slot so the completion push can never overflow
  assign can_launch = (cmd_count != '0) && (rsp_count_nx < LVL_FULL);

  // Transfer FSM next-state
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_o;
    penable_d = penable_o;
    wait_d    = wait_q;
    launch    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (can_launch) begin
          launch  = 1'b1;
          psel_d  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready_i) begin
          penable_d = 1'b0;
          wait_d    = '0;
          if (can_launch) begin
            launch  = 1'b1;
            state_d = ST_SETUP;
          end else begin
            psel_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (timeout_hit) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          wait_d    = '0;
          state_d   = ST_IDLE;
        end else if (TIMEOUT != 0) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        wait_d    = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State, APB request and status registers
  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      state_q   <= ST_IDLE;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      wait_q    <= '0;
      busy_o    <= 1'b0;
      paddr_o   <= '0;
      pwrite_o  <= 1'b0;
      pwdata_o  <= '0;
      pstrb_o   <= '0;
      pprot_o   <= '0;
    end else begin
      state_q   <= state_d;
      psel_o    <= psel_d;
      penable_o <= penable_d;
      wait_q    <= wait_d;
      busy_o    <= (state_d != ST_IDLE) || (cmd_count_d != '0);
      if (launch) begin
        paddr_o  <= cmd_head.addr;
        pwrite_o <= cmd_head.write;
        pprot_o  <= cmd_head.prot;
        pwdata_o <= cmd_head.write ? cmd_head.wdata : '0;
        pstrb_o  <= cmd_head.write ? cmd_head.strb : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_fifo.sv
// Scoreboard bench for apb_master_fifo: a planned APB slave model plus an
// in-order expected-response queue built from each command's plan.
module tb_apb_master_fifo;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO = 8;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    strb;
    logic [2:0]    prot;
    int            waits;
    logic [DW-1:0] rdata;
    logic          err;
  } plan_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
  } exp_t;

  logic          pclk_i, prstn_i;
  logic [AW-1:0] paddr_o;
  logic [2:0]    pprot_o;
  logic          psel_o, penable_o, pwrite_o;
  logic [DW-1:0] pwdata_o;
  logic [3:0]    pstrb_o;
  logic          pready_i, pslverr_i;
  logic [DW-1:0] prdata_i;
  logic          cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_wdata_i;
  logic [3:0]    cmd_strb_i;
  logic [2:0]    cmd_prot_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
  logic [DW-1:0] rsp_rdata_o;
  logic [2:0]    cmd_level_o;
  logic          busy_o;

  apb_master_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .pclk_i(pclk_i), .prstn_i(prstn_i),
    .paddr_o(paddr_o), .pprot_o(pprot_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
    .cmd_prot_i(cmd_prot_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .cmd_level_o(cmd_level_o), .busy_o(busy_o)
  );

  int    n_cmp = 0;
  int    n_fail = 0;
  int    comps = 0;
  bit    rand_rdy = 0;
  plan_t plan_q[$];
  exp_t  exp_q[$];

  initial pclk_i = 1'b0;
  always #5 pclk_i = ~pclk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the requester must report for a command given the slave's plan
  function automatic exp_t model(input plan_t p);
    exp_t e;
    if (TO != 0 && p.waits >= int'(TO)) begin
      e.rdata = '0; e.err = 1'b1; e.to = 1'b1;
    end else begin
      e.rdata = p.write ? '0 : p.rdata; e.err = p.err; e.to = 1'b0;
    end
    return e;
  endfunction

  function automatic plan_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [3:0] s, input int waits, input logic [DW-1:0] rd,
                               input logic err);
    plan_t p;
    p.write = w; p.addr = a; p.wdata = d; p.strb = s; p.prot = 3'($urandom);
    p.waits = waits; p.rdata = rd; p.err = err;
    return p;
  endfunction

  function automatic plan_t rand_plan();
    int waits;
    waits = ($urandom % 5 == 0) ? int'($urandom_range(7, 11)) : int'($urandom_range(0, 3));
    return mk(1'($urandom), $urandom, $urandom, 4'($urandom), waits, $urandom,
              ($urandom % 4) == 0);
  endfunction

  // Call at posedge+#1; returns at posedge+#1 of the accepting edge
  task automatic send(input plan_t p);
    int guard = 0;
    cmd_valid_i = 1'b1; cmd_write_i = p.write; cmd_addr_i = p.addr;
    cmd_wdata_i = p.wdata; cmd_strb_i = p.strb; cmd_prot_i = p.prot;
    @(negedge pclk_i);
    while (!cmd_ready_o && guard < 300) begin
      guard++;
      @(negedge pclk_i);
    end
    if (!cmd_ready_o) chk("cmd_accept_timeout", 64'(cmd_ready_o), 64'd1);
    else begin
      plan_q.push_back(p);
      exp_q.push_back(model(p));
    end
    @(posedge pclk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge pclk_i);
    #1;
  endtask

  // Width in cycles of the next high pulse on psel (sel=0) or penable (sel=1)
  task automatic measure(input bit sel, output int width);
    int guard = 0;
    width = 0;
    @(negedge pclk_i);
    while (((sel ? penable_o : psel_o) == 1'b0) && guard < 200) begin
      guard++;
      @(negedge pclk_i);
    end
    while (((sel ? penable_o : psel_o) == 1'b1) && width < 200) begin
      width++;
      @(negedge pclk_i);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || busy_o) && guard < 3000) begin
      guard++;
      cycles(1);
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    cycles(1);
  endtask

  // APB slave model: follows the plan of the transfer currently in ACCESS
  plan_t cur;
  bit    active = 0;
  int    wcnt = 0;
  always @(posedge pclk_i) begin
    #1;
    if (!prstn_i) begin
      active = 0; pready_i = 1'b0;
    end else if (psel_o && penable_o) begin
      if (!active) begin
        active = 1; wcnt = 0;
        if (plan_q.size() == 0) begin
          chk("unplanned_transfer", 64'd1, 64'd0);
          cur = mk(1'b0, '0, '0, '0, 0, '0, 1'b0);
        end else cur = plan_q.pop_front();
      end else wcnt++;
      chk("paddr", 64'(paddr_o), 64'(cur.addr));
      chk("pwrite", 64'(pwrite_o), 64'(cur.write));
      chk("pprot", 64'(pprot_o), 64'(cur.prot));
      chk("pwdata", 64'(pwdata_o), cur.write ? 64'(cur.wdata) : 64'd0);
      chk("pstrb", 64'(pstrb_o), cur.write ? 64'(cur.strb) : 64'd0);
      if (wcnt >= cur.waits) begin
        pready_i = 1'b1; prdata_i = cur.rdata; pslverr_i = cur.err;
      end else begin
        pready_i = 1'b0; prdata_i = $urandom; pslverr_i = 1'($urandom);
      end
    end else begin
      active = 0;
      pready_i = 1'($urandom); prdata_i = $urandom; pslverr_i = 1'($urandom);
    end
  end

  always @(negedge pclk_i) begin
    if (psel_o && penable_o && pready_i) comps++;
  end

  // Response monitor / scoreboard
  always @(negedge pclk_i) begin
    exp_t e;
    if (prstn_i && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL rsp_unexpected: got rdata 0x%0h err %0b timeout %0b, none required",
                 rsp_rdata_o, rsp_err_o, rsp_timeout_o);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
        chk("rsp_err", 64'(rsp_err_o), 64'(e.err));
        chk("rsp_timeout", 64'(rsp_timeout_o), 64'(e.to));
      end
    end
  end

  always @(posedge pclk_i) begin
    #1;
    if (rand_rdy) rsp_ready_i = ($urandom % 3) != 0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int snap;
    prstn_i = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0;
    cmd_wdata_i = '0; cmd_strb_i = '0; cmd_prot_i = '0; rsp_ready_i = 1'b1;
    pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;
    cycles(3);
    chk("rst_psel", 64'(psel_o), 64'd0);
    chk("rst_penable", 64'(penable_o), 64'd0);
    chk("rst_paddr", 64'(paddr_o), 64'd0);
    chk("rst_pwdata", 64'(pwdata_o), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_level", 64'(cmd_level_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    @(negedge pclk_i); prstn_i = 1'b1;
    cycles(2);

    // Single write: psel N+1, penable N+2, response from N+3
    send(mk(1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF, 0, 32'h0, 1'b0));
    chk("t1_psel_n", 64'(psel_o), 64'd0);
    cycles(1);
    chk("t1_psel_n1", 64'(psel_o), 64'd1);
    chk("t1_penable_n1", 64'(penable_o), 64'd0);
    chk("t1_pstrb_n1", 64'(pstrb_o), 64'hF);
    cycles(1);
    chk("t1_penable_n2", 64'(penable_o), 64'd1);
    chk("t1_rsp_n2", 64'(rsp_valid_o), 64'd0);
    cycles(1);
    chk("t1_rsp_n3", 64'(rsp_valid_o), 64'd1);
    chk("t1_psel_n3", 64'(psel_o), 64'd0);
    drain();

    // Four back-to-back reads: psel continuously high for 8 cycles
    fork
      for (int i = 1; i <= 4; i++) send(mk(1'b0, 32'h100 + 32'(4 * i), $urandom, 4'($urandom), 0, 32'(i), 1'b0));
      measure(1'b0, w);
    join
    chk("t2_psel_run", 64'(w), 64'd8);
    drain();

    // Three wait states ending in a slave error
    fork
      send(mk(1'b0, 32'h200, 32'h0, 4'h0, 3, 32'hDEAD_BEEF, 1'b1));
      measure(1'b1, w);
    join
    chk("t3_penable_width", 64'(w), 64'd4);
    drain();

    // Stuck pready: abort after TIMEOUT access cycles, next command still runs
    fork
      begin
        send(mk(1'b0, 32'h300, 32'h0, 4'h0, 50, 32'h1234, 1'b0));
        send(mk(1'b1, 32'h304, 32'h5555_AAAA, 4'h3, 1, 32'h0, 1'b0));
      end
      measure(1'b1, w);
    join
    chk("t4_penable_width", 64'(w), 64'(TO));
    drain();

    // Response FIFO back-pressure: only DEPTH transfers issue
    rsp_ready_i = 1'b0;
    snap = comps;
    for (int i = 0; i < 2 * int'(DEPTH); i++)
      send(mk(1'b0, 32'h400 + 32'(4 * i), $urandom, 4'($urandom), 0, $urandom, 1'b0));
    cycles(12);
    chk("t5_transfers", 64'(comps - snap), 64'(DEPTH));
    chk("t5_level", 64'(cmd_level_o), 64'(DEPTH));
    chk("t5_cmd_ready", 64'(cmd_ready_o), 64'd0);
    chk("t5_rsp_valid", 64'(rsp_valid_o), 64'd1);
    chk("t5_busy", 64'(busy_o), 64'd1);
    rsp_ready_i = 1'b1;
    drain();
    chk("t5_all_transfers", 64'(comps - snap), 64'(2 * DEPTH));

    // Reset during ACCESS with two commands still queued
    for (int i = 0; i < 3; i++) send(mk(1'b0, 32'h500 + 32'(4 * i), '0, '0, 6, $urandom, 1'b0));
    chk("t6_level_before", 64'(cmd_level_o), 64'd2);
    chk("t6_penable_before", 64'(penable_o), 64'd1);
    @(negedge pclk_i); #1;
    prstn_i = 1'b0;
    #1;
    chk("t6_psel", 64'(psel_o), 64'd0);
    chk("t6_penable", 64'(penable_o), 64'd0);
    chk("t6_level", 64'(cmd_level_o), 64'd0);
    chk("t6_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("t6_cmd_ready", 64'(cmd_ready_o), 64'd1);
    plan_q.delete();
    exp_q.delete();
    cycles(2);
    @(negedge pclk_i); prstn_i = 1'b1;
    snap = comps;
    cycles(15);
    chk("t6_no_rsp", 64'(rsp_valid_o), 64'd0);
    chk("t6_no_transfer", 64'(comps - snap), 64'd0);
    chk("t6_busy", 64'(busy_o), 64'd0);

    // Randomized traffic with random response back-pressure
    rand_rdy = 1;
    for (int i = 0; i < 60; i++) begin
      send(rand_plan());
      if ($urandom % 3 == 0) cycles(int'($urandom_range(1, 3)));
    end
    drain();
    rand_rdy = 0;
    cycles(2);
    rsp_ready_i = 1'b1;
    cycles(2);
    chk("end_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("end_plans_left", 64'(plan_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_fifo.md
# apb_master_fifo

Queued APB4 requester: accepts commands on a valid/ready port into a CMD_DEPTH-entry command FIFO, issues them as APB transfers, and returns one response per command through a response FIFO of the same depth. Adds per-transfer strobes and protection, slave-error reporting, a wait-state timeout and zero-gap back-to-back transfers. Sits between a CSR/DMA-side controller and the APB interconnect, replacing the single-shot pulse-driven master.

## Interface
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width (8, 16 or 32)
- CMD_DEPTH, 4, command and response FIFO depth (power of 2, ≥2)
- TIMEOUT, 256, maximum ACCESS cycles with pready low before abort (0 disables)
- pclk_i  in  1  clock
- prstn_i  in  1  reset, asynchronous, active-low
- paddr_o / pprot_o / psel_o / penable_o / pwrite_o  out  ADDR_WIDTH/3/1/1/1  APB request
- pwdata_o / pstrb_o  out  DATA_WIDTH / DATA_WIDTH/8  write data, byte strobes
- pready_i / prdata_i / pslverr_i  in  1/DATA_WIDTH/1  APB completion
- cmd_valid_i / cmd_ready_o  in/out  1/1  command handshake
- cmd_write_i / cmd_addr_i / cmd_wdata_i / cmd_strb_i / cmd_prot_i  in  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8/3  command fields
- rsp_valid_o / rsp_ready_i  out/in  1/1  response handshake
- rsp_rdata_o / rsp_err_o / rsp_timeout_o  out  DATA_WIDTH/1/1  response fields
- cmd_level_o  out  $clog2(CMD_DEPTH)+1  command FIFO occupancy
- busy_o  out  1  high when FSM not IDLE or command FIFO non-empty

## Operation
- Command accepted on edge with cmd_valid_i && cmd_ready_o; cmd_ready_o = command FIFO not full (combinational from count).
- FSM: IDLE, SETUP, ACCESS.
- Launch condition L = command FIFO non-empty && (response FIFO count after this edge's push/pop) < CMD_DEPTH.
- IDLE: if L → SETUP, pop command, load paddr/pwrite/pwdata/pstrb/pprot, psel=1.
- SETUP → ACCESS unconditionally, penable=1.
- ACCESS, pready_i=1: push response {rdata = write?0:prdata_i, err = pslverr_i, timeout=0}; penable=0; if L → SETUP with next command (psel stays 1), else → IDLE, psel=0.
- ACCESS, pready_i=0: wait-counter increments; when counter == TIMEOUT−1 (TIMEOUT≠0) → IDLE, psel=penable=0, push {rdata=0, err=1, timeout=1}.
- pslverr_i and prdata_i sampled only when psel&&penable&&pready_i.
- Reads drive pstrb_o=0 and pwdata_o=0; writes drive cmd_strb_i unmodified (strb=0 write still issued).
- In IDLE paddr/pwrite/pprot hold last values; pwdata/pstrb hold.
- Every accepted command yields exactly one response, in order.
- Response FIFO full with rsp_ready_i=0: launches stall; rsp fields held stable while rsp_valid_o=1.
- Command FIFO full: cmd_ready_o=0; push blocked even if a pop occurs same edge.
- Simultaneous push/pop on either FIFO: count unchanged, both take effect.

## Timing
- Reset: psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, pprot_o, rsp_* , busy_o, cmd_level_o, wait counter = 0; state IDLE; cmd_ready_o=1.
- Reset asserted mid-transfer: psel/penable drop asynchronously, both FIFOs emptied, no response generated.
- Command accepted at edge N, FIFOs empty, pready=1: psel high cycle N+1, penable cycle N+2, rsp_valid_o high from edge N+3.
- Back-to-back: one transfer every 2 cycles, psel continuously high.
- Each wait state adds one cycle; address/control/data stable from SETUP through completion.
- Timeout with TIMEOUT=T: psel falls T cycles after penable rose.

## Test plan
- Single write addr 0x10, data 0xA5A5_A5A5, strb 0xF, pready=1 → psel N+1, penable N+2, pstrb 0xF, rsp at N+3 err=0 rdata=0.
- Four queued reads, slave returns 0x1..0x4, zero wait → psel high 8 cycles contiguous, responses 0x1..0x4 in order.
- Read with 3 wait states then pslverr=1 → penable high 4 cycles, rsp err=1, timeout=0, rdata = prdata at completion.
- TIMEOUT=8, pready stuck low → abort after 8 ACCESS cycles, rsp err=1 timeout=1 rdata=0, next command proceeds.
- rsp_ready_i=0, push 2×CMD_DEPTH commands → exactly CMD_DEPTH transfers issued, cmd_ready_o=0 at level CMD_DEPTH; release rsp_ready → remainder completes, in order.
- prstn_i asserted during ACCESS with 2 queued → outputs zero immediately, cmd_level_o=0, no rsp_valid after release.
